seg_nios2_debug_ocimem_sequencer: RTL and testbench
===================================================

Name: seg_nios2_debug_ocimem_sequencer

Overview:
Sysclk-side controller that turns the debug slave's decoded JTAG command strobes (jdo plus take_action_ocimem_* pulses) into single-beat accesses on an Avalon-style memory port. It holds a current address with auto-increment, returns read data and status to the debug slave (MonDReg, monitor_ready, monitor_error), and aborts stalled accesses with a timeout. It sits between the debug slave wrapper outputs and the on-chip debug memory / OCI register port of the Nios II core.

Parameters:
ADDR_W, 8, word-address width of the memory port; current address wraps at 2^ADDR_W.
TIMEOUT, 255, maximum cycles a request may be held under mem_waitrequest before abort (1..65535).

Ports:
clk  in  1  system clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
jdo  in  38  debug-slave data word; fields defined under Behaviour.
take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read.
take_action_ocimem_b  in  1  one-cycle strobe: write data at current address.
take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address.
mem_address  out  ADDR_W  memory word address.
mem_read  out  1  read request, held until accepted.
mem_write  out  1  write request, held until accepted.
mem_writedata  out  32  write data.
mem_readdata  in  32  read data, valid in the accept cycle of a read.
mem_waitrequest  in  1  stall; request accepted on a cycle with request high and waitrequest low.
MonDReg  out  32  last read data returned to debug slave.
monitor_ready  out  1  high when idle and last command complete.
monitor_error  out  1  sticky error flag.

Behaviour:
- Reset values: mem_address 0, mem_read 0, mem_write 0, mem_writedata 0, MonDReg 0, monitor_ready 1, monitor_error 0, internal address 0, timeout counter 0, state IDLE.
- jdo fields: address = jdo[17+ADDR_W-1:17]; read flag = jdo[34] (ocimem_a only); write data = jdo[34:3] (ocimem_b only).
- States: IDLE, RD, WR.
- IDLE + ocimem_a: current address <= address field; monitor_error <= 0. If read flag is 1: go to RD at the loaded address and clear monitor_ready. Otherwise stay IDLE with monitor_ready 1.
- IDLE + ocimem_b: mem_writedata <= data field; go to WR; monitor_ready <= 0.
- IDLE + no_action_ocimem_a: go to RD; monitor_ready <= 0.
- Request timing: a strobe in cycle N drives mem_read/mem_write high with mem_address = current address from cycle N+1.
- RD accept: MonDReg <= mem_readdata. Address increments. mem_read drops next cycle. Return to IDLE with monitor_ready 1.
- WR accept: address increments, mem_write drops, return to IDLE with monitor_ready 1.
- Minimum latency: strobe at N with waitrequest low -> accept at N+1 -> MonDReg and monitor_ready updated at N+2.
- Address increment is modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0.
- Timeout: counter clears on entry to RD/WR and increments each cycle with mem_waitrequest high. When it reaches TIMEOUT:
  - request deasserts next cycle, return to IDLE;
  - monitor_error <= 1, monitor_ready <= 1;
  - address and MonDReg unchanged.
- Strobe while in RD/WR: ignored, monitor_error <= 1; the in-flight access continues unaffected.
- Simultaneous strobes in IDLE: priority ocimem_a > ocimem_b > no_action_ocimem_a. Only the winner executes; monitor_error <= 1, except the winning ocimem_a's own clear does not apply in that cycle, so the error stays set.
- monitor_error clears only on an ocimem_a accepted alone in IDLE, or on reset.
- mem_read and mem_write are never high together. The request and mem_address are stable while waitrequest is high.
- Asynchronous reset mid-access: mem_read/mem_write deassert immediately, all registers return to reset values.

Test Plan:
- Load/read: ocimem_a with addr 0x10 and read flag 1, mem_readdata 0xDEADBEEF, waitrequest 0 -> mem_read at N+1 with mem_address 0x10; MonDReg 0xDEADBEEF and monitor_ready 1 at N+2; next no_action read uses address 0x11.
- Write with stall: ocimem_a addr 0x05, flag 0, then ocimem_b data 0x12345678, waitrequest held 3 cycles -> mem_write held with address 0x05 and data stable for 4 cycles; then monitor_ready 1 and address 0x06.
- Wrap: ADDR_W=8, load 0xFF, two reads -> mem_address 0xFF then 0x00.
- Timeout: TIMEOUT=4, read with waitrequest stuck high -> mem_read drops after 4 stalled cycles; monitor_error 1, monitor_ready 1, MonDReg unchanged; next lone ocimem_a clears the error.
- Collision: ocimem_b and no_action strobed together in IDLE -> only the write issues, monitor_error 1. A strobe during a stalled read -> ignored, error 1, the read completes normally.
- Reset mid-read: reset_n low while mem_read is high -> mem_read 0 immediately, MonDReg 0, monitor_ready 1, address 0.

Source files
------------

// File: rtl/seg_nios2_debug_ocimem_sequencer.sv
// Debug-memory access sequencer.
// Turns the debug slave's decoded OCI memory command strobes into single-beat
// Avalon-style read/write requests. It keeps a current word address that
// auto-increments, returns read data and status, and aborts stalled accesses
// with a timeout.
module seg_nios2_debug_ocimem_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // Abort fires on the stalled cycle in which the counter would reach TIMEOUT.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       tmo_reg, tmo_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       dreg_reg, dreg_next;
  logic              ready_reg, ready_next;
  logic              error_reg, error_next;
  logic              any_strobe;
  logic              multi_strobe;

  // jdo bits outside the address and data fields carry nothing for this block.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);

  // Requests come straight from the state register, so reset drops them at once
  // and they stay stable while the slave stalls.
  assign mem_read      = (state_reg == RD);
  assign mem_write     = (state_reg == WR);
  assign mem_address   = addr_reg;
  assign mem_writedata = wdata_reg;
  assign MonDReg       = dreg_reg;
  assign monitor_ready = ready_reg;
  assign monitor_error = error_reg;

  // Next-state and command decode; everything holds unless a case below updates it.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    tmo_next   = tmo_reg;
    wdata_next = wdata_reg;
    dreg_next  = dreg_reg;
    ready_next = ready_reg;
    error_next = error_reg;
    case (state_reg)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_next  = jdo[17+ADDR_W-1:17];
          // A lone ocimem_a clears the error; a collision keeps it set.
          error_next = multi_strobe;
          if (jdo[34]) begin
            state_next = RD;
            ready_next = 1'b0;
            tmo_next   = '0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_next = jdo[34:3];
          state_next = WR;
          ready_next = 1'b0;
          tmo_next   = '0;
          error_next = error_reg | multi_strobe;
        end else if (take_no_action_ocimem_a) begin
          state_next = RD;
          ready_next = 1'b0;
          tmo_next   = '0;
        end
      end
      RD, WR: begin
        // Commands arriving mid-access are dropped and flagged.
        if (any_strobe) error_next = 1'b1;
        if (!mem_waitrequest) begin
          if (state_reg == RD) dreg_next = mem_readdata;
          addr_next  = addr_reg + 1'b1;
          state_next = IDLE;
          ready_next = 1'b1;
        end else begin
          tmo_next = tmo_reg + 16'd1;
          if (tmo_reg == TIMEOUT_LAST) begin
            state_next = IDLE;
            ready_next = 1'b1;
            error_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      tmo_reg   <= '0;
      wdata_reg <= '0;
      dreg_reg  <= '0;
      ready_reg <= 1'b1;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      tmo_reg   <= tmo_next;
      wdata_reg <= wdata_next;
      dreg_reg  <= dreg_next;
      ready_reg <= ready_next;
      error_reg <= error_next;
    end
  end

endmodule

// File: tb/tb_seg_nios2_debug_ocimem_sequencer.sv
// Directed bench for the OCI memory sequencer: one table of per-cycle vectors
// plus hand-written timeout and asynchronous-reset sequences.
module tb_seg_nios2_debug_ocimem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seg_nios2_debug_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_readdata            (mem_readdata),
    .mem_waitrequest         (mem_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  typedef struct {
    logic        a, b, na;
    logic [37:0] jdo;
    logic        wait_req;
    logic [31:0] rdata;
    logic        exp_rd, exp_wr;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata, exp_dreg;
    logic        exp_ready, exp_err;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [37:0] ja(input logic [7:0] addr, input logic rflag);
    logic [37:0] j;
    j = '0;
    j[24:17] = addr;
    j[34] = rflag;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  function automatic vec_t mkv(input logic a, b, na, input logic [37:0] j,
                               input logic w, input logic [31:0] rd,
                               input logic erd, ewr, input logic [7:0] ead,
                               input logic [31:0] ewd, edr, input logic erdy, eerr);
    vec_t v;
    v.a = a; v.b = b; v.na = na; v.jdo = j; v.wait_req = w; v.rdata = rd;
    v.exp_rd = erd; v.exp_wr = ewr; v.exp_addr = ead; v.exp_wdata = ewd;
    v.exp_dreg = edr; v.exp_ready = erdy; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic a, b, na, input logic [37:0] j,
                       input logic w, input logic [31:0] rd);
    @(negedge clk);
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    jdo = j;
    mem_waitrequest = w;
    mem_readdata = rd;
  endtask

  task automatic chk_state(input string tag, input logic erd, ewr, input logic [7:0] ead,
                           input logic [31:0] edr, input logic erdy, eerr);
    chk({tag, " mem_read"},      32'(mem_read),      32'(erd));
    chk({tag, " mem_write"},     32'(mem_write),     32'(ewr));
    chk({tag, " mem_address"},   32'(mem_address),   32'(ead));
    chk({tag, " MonDReg"},       MonDReg,            edr);
    chk({tag, " monitor_ready"}, 32'(monitor_ready), 32'(erdy));
    chk({tag, " monitor_error"}, 32'(monitor_error), 32'(eerr));
  endtask

  initial begin
    // cycle-by-cycle vectors: inputs for one cycle, state observed after its edge
    vecs[0]  = mkv(1,0,0, ja(8'h10,1), 0, 32'hDEADBEEF, 1,0,8'h10, 32'h0,        32'h0,        0,0);
    vecs[1]  = mkv(0,0,0, '0,          0, 32'hDEADBEEF, 0,0,8'h11, 32'h0,        32'hDEADBEEF, 1,0);
    vecs[2]  = mkv(0,0,1, '0,          0, 32'h0,        1,0,8'h11, 32'h0,        32'hDEADBEEF, 0,0);
    vecs[3]  = mkv(0,0,0, '0,          0, 32'hCAFEF00D, 0,0,8'h12, 32'h0,        32'hCAFEF00D, 1,0);
    vecs[4]  = mkv(1,0,0, ja(8'h05,0), 0, 32'h0,        0,0,8'h05, 32'h0,        32'hCAFEF00D, 1,0);
    vecs[5]  = mkv(0,1,0, jb(32'h12345678), 1, 32'h0,   0,1,8'h05, 32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[6]  = mkv(0,0,0, '0,          1, 32'h0,        0,1,8'h05, 32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[7]  = mkv(0,0,0, '0,          1, 32'h0,        0,1,8'h05, 32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[8]  = mkv(0,0,0, '0,          1, 32'h0,        0,1,8'h05, 32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[9]  = mkv(0,0,0, '0,          0, 32'h0,        0,0,8'h06, 32'h12345678, 32'hCAFEF00D, 1,0);
    vecs[10] = mkv(1,0,0, ja(8'hFF,1), 0, 32'h0,        1,0,8'hFF, 32'h12345678, 32'hCAFEF00D, 0,0);
    vecs[11] = mkv(0,0,0, '0,          0, 32'h11111111, 0,0,8'h00, 32'h12345678, 32'h11111111, 1,0);
    vecs[12] = mkv(0,0,1, '0,          0, 32'h0,        1,0,8'h00, 32'h12345678, 32'h11111111, 0,0);
    vecs[13] = mkv(0,0,0, '0,          0, 32'h22222222, 0,0,8'h01, 32'h12345678, 32'h22222222, 1,0);
    vecs[14] = mkv(0,1,1, jb(32'hA5A5A5A5), 0, 32'h0,   0,1,8'h01, 32'hA5A5A5A5, 32'h22222222, 0,1);
    vecs[15] = mkv(0,0,0, '0,          0, 32'h0,        0,0,8'h02, 32'hA5A5A5A5, 32'h22222222, 1,1);
    vecs[16] = mkv(1,0,0, ja(8'h20,0), 0, 32'h0,        0,0,8'h20, 32'hA5A5A5A5, 32'h22222222, 1,0);
    vecs[17] = mkv(0,0,1, '0,          1, 32'h0,        1,0,8'h20, 32'hA5A5A5A5, 32'h22222222, 0,0);
    vecs[18] = mkv(0,0,1, '0,          1, 32'h0,        1,0,8'h20, 32'hA5A5A5A5, 32'h22222222, 0,1);
    vecs[19] = mkv(0,0,0, '0,          0, 32'h33333333, 0,0,8'h21, 32'hA5A5A5A5, 32'h33333333, 1,1);
    vecs[20] = mkv(1,1,0, ja(8'h30,0), 0, 32'h0,        0,0,8'h30, 32'hA5A5A5A5, 32'h33333333, 1,1);
    vecs[21] = mkv(1,0,0, ja(8'h30,0), 0, 32'h0,        0,0,8'h30, 32'hA5A5A5A5, 32'h33333333, 1,0);

    // reset state
    repeat (2) @(negedge clk);
    chk_state("reset", 0, 0, 8'h00, 32'h0, 1, 0);
    chk("reset mem_writedata", mem_writedata, 32'h0);
    reset_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].na, vecs[i].jdo, vecs[i].wait_req, vecs[i].rdata);
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_addr,
                vecs[i].exp_dreg, vecs[i].exp_ready, vecs[i].exp_err);
      chk($sformatf("vec%0d mem_writedata", i), mem_writedata, vecs[i].exp_wdata);
      $display("vec%0d: a=%0b b=%0b na=%0b wait=%0b -> rd=%0b wr=%0b addr=%02h dreg=%08h rdy=%0b err=%0b",
               i, vecs[i].a, vecs[i].b, vecs[i].na, vecs[i].wait_req, mem_read, mem_write,
               mem_address, MonDReg, monitor_ready, monitor_error);
    end

    // timeout: read held 4 stalled cycles, then dropped with error
    drive(0, 0, 1, '0, 1, 32'hBADBAD00);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("timeout mem_read c%0d", c), 32'(mem_read), (c < 4) ? 32'd1 : 32'd0);
      if (c == 0) drive(0, 0, 0, '0, 1, 32'hBADBAD00);
    end
    chk_state("timeout end", 0, 0, 8'h30, 32'h33333333, 1, 1);
    $display("timeout: rd=%0b addr=%02h dreg=%08h rdy=%0b err=%0b",
             mem_read, mem_address, MonDReg, monitor_ready, monitor_error);
    drive(1, 0, 0, ja(8'h40, 0), 0, 32'h0);
    @(posedge clk); #1;
    chk_state("err clear", 0, 0, 8'h40, 32'h33333333, 1, 0);
    $display("err clear: addr=%02h err=%0b", mem_address, monitor_error);

    // asynchronous reset in the middle of a stalled read
    drive(0, 0, 1, '0, 1, 32'h0);
    @(posedge clk); #1;
    chk("pre-reset mem_read", 32'(mem_read), 32'd1);
    drive(0, 0, 0, '0, 1, 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_state("async reset", 0, 0, 8'h00, 32'h0, 1, 0);
    $display("async reset: rd=%0b addr=%02h dreg=%08h rdy=%0b",
             mem_read, mem_address, MonDReg, monitor_ready);
    @(negedge clk);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
